// File: rtl/riscv_core_instr_aligner.sv
// Fetch-side aligner: splits 32-bit fetch words into halfwords and emits one (compressed or 32-bit) instruction per handshake.
// Latency: a word accepted in cycle N gives its first instruction on the registered outputs in cycle N+2.
// Backpressure: fetch_ready only while <=1 halfword is buffered; outputs hold while valid && !ready. RVC support under RISCV_CORE_RVC_EN.
module riscv_core_instr_aligner #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_instr_aligner_fetch_valid,
  input  logic [31:0]     i_instr_aligner_fetch_data,
  output logic            o_instr_aligner_fetch_ready,
  input  logic            i_instr_aligner_flush,
  input  logic [XLEN-1:0] i_instr_aligner_flush_pc,
  output logic            o_instr_aligner_valid,
  input  logic            i_instr_aligner_ready,
  output logic [31:0]     o_instr_aligner_instr,
  output logic [XLEN-1:0] o_instr_aligner_pc,
  output logic            o_instr_aligner_is_compressed
);

  // Halfword buffer, entry 0 is the head (lowest address).
  logic [2:0][15:0] hw_q, hw_d;
  logic [1:0]       count_q, count_d;
  logic [XLEN-1:0]  head_pc_q, head_pc_d;
  logic [XLEN-1:0]  flush_head_pc;
  logic             skip_q;
  logic             head_is_comp;
  logic             can_emit;
  logic             accept;
  logic [1:0]       need, emit_n, base, app_n;
  logic [31:0]      head_instr;
  logic             unused_flush_lsbs;

  // Only registered state decides whether a new word fits (<=1 entry leaves room for 2).
  assign o_instr_aligner_fetch_ready = (count_q <= 2'd1);
  assign accept = i_instr_aligner_fetch_valid && o_instr_aligner_fetch_ready;
  assign unused_flush_lsbs = ^i_instr_aligner_flush_pc[1:0];

`ifdef RISCV_CORE_RVC_EN
  assign head_is_comp  = (hw_q[0][1:0] != 2'b11);
  assign flush_head_pc = {i_instr_aligner_flush_pc[XLEN-1:1], 1'b0};

  // A redirect to the upper halfword of a word means the next word's low half is skipped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      skip_q <= 1'b0;
    end else if (i_instr_aligner_flush) begin
      skip_q <= i_instr_aligner_flush_pc[1];
    end else if (accept) begin
      skip_q <= 1'b0;
    end
  end
`else
  assign head_is_comp  = 1'b0;
  assign flush_head_pc = {i_instr_aligner_flush_pc[XLEN-1:2], 2'b00};
  assign skip_q        = 1'b0;
`endif

  assign head_instr = head_is_comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};

  // Emit decision uses the buffer as it stood at the start of the cycle; the word
  // accepted this cycle is appended behind whatever remains after the shift.
  always_comb begin
    need     = head_is_comp ? 2'd1 : 2'd2;
    can_emit = (count_q >= need) && (!o_instr_aligner_valid || i_instr_aligner_ready);
    emit_n   = can_emit ? need : 2'd0;
    base     = count_q - emit_n;
    hw_d     = hw_q;
    if (emit_n == 2'd1) begin
      hw_d = {16'h0000, hw_q[2], hw_q[1]};
    end else if (emit_n == 2'd2) begin
      hw_d = {32'h0, hw_q[2]};
    end
    app_n = 2'd0;
    if (accept) begin
      if (skip_q) begin
        hw_d[base] = i_instr_aligner_fetch_data[31:16];
        app_n      = 2'd1;
      end else begin
        hw_d[base]        = i_instr_aligner_fetch_data[15:0];
        hw_d[base + 2'd1] = i_instr_aligner_fetch_data[31:16];
        app_n             = 2'd2;
      end
    end
    count_d   = base + app_n;
    head_pc_d = head_pc_q + {{(XLEN-3){1'b0}}, emit_n, 1'b0};
  end

  // Buffer, head PC and output registers; reset beats flush, flush beats fetch/emit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hw_q                          <= '0;
      count_q                       <= 2'd0;
      head_pc_q                     <= '0;
      o_instr_aligner_valid         <= 1'b0;
      o_instr_aligner_instr         <= 32'h0;
      o_instr_aligner_pc            <= '0;
      o_instr_aligner_is_compressed <= 1'b0;
    end else if (i_instr_aligner_flush) begin
      count_q               <= 2'd0;
      head_pc_q             <= flush_head_pc;
      o_instr_aligner_valid <= 1'b0;
    end else begin
      hw_q      <= hw_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      if (can_emit) begin
        o_instr_aligner_valid         <= 1'b1;
        o_instr_aligner_instr         <= head_instr;
        o_instr_aligner_pc            <= head_pc_q;
        o_instr_aligner_is_compressed <= head_is_comp;
      end else if (!o_instr_aligner_valid || i_instr_aligner_ready) begin
        o_instr_aligner_valid <= 1'b0;
      end
    end
  end

endmodule
